// File: rtl/data_mem_wait.sv
// Word-addressed data memory for the MEM stage with a fixed, parametrised
// access latency. While an access is outstanding, ready is low so that
// upstream logic can freeze the pipeline on ~ready. Accesses that are out of
// range or misaligned complete normally but raise addr_err and have no effect.
module data_mem_wait #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 64,
   parameter int ADDR_BASE   = 1024,
   parameter int WAIT_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [31:0]       address,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              addr_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // 33-bit bounds so that the upper limit cannot wrap for bases near 2^32
   localparam logic [32:0]      ADDR_LO  = 33'(ADDR_BASE);
   localparam logic [32:0]      ADDR_HI  = 33'(ADDR_BASE) + 33'(4 * DEPTH);
   localparam logic [31:0]      BASE     = 32'(ADDR_BASE);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              req;
   logic              addr_ok;
   logic              done;
   logic [IDX_W-1:0]  idx;

   // Decode the request and form the combinational handshake and read data
   always_comb begin
      req     = mem_r_en | mem_w_en;
      addr_ok = ({1'b0, address} >= ADDR_LO) &&
                ({1'b0, address} <  ADDR_HI) &&
                (address[1:0] == 2'b00);
      // Word index relative to the base; only meaningful when addr_ok
      idx     = address[IDX_W+1:2] - BASE[IDX_W+1:2];

      // done marks the completion cycle of a live (non-aborted) access
      done = 1'b0;
      if (rst && req) begin
         if (state == S_IDLE)
            done = (WAIT_CYCLES == 0);
         else
            done = (cnt == CNT_LAST);
      end

      // Reset forces ready high even with a request present
      ready    = !rst || !req || done;
      addr_err = done && !addr_ok;

      // A simultaneous read/write is treated as a write, so no read data
      rdata = '0;
      if (done && !mem_w_en && addr_ok)
         rdata = mem[idx];
   end

   // Access sequencer: count stall cycles, return to idle on completion or abort
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req && (WAIT_CYCLES != 0)) begin
                  state <= S_WAIT;
                  cnt   <= CNT_ONE;
               end
            end
            S_WAIT: begin
               if (!req || (cnt == CNT_LAST)) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Storage array: cleared by reset, written only at a good write's completion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (done && mem_w_en && addr_ok) begin
         mem[idx] <= wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_wait.sv
// Bench for data_mem_wait: one instance with three wait cycles (A) and one
// with zero wait cycles (B). Drivers push expected responses into per-instance
// queues; monitors pop and compare at every completion cycle.
module tb_data_mem_wait;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WAIT_CYCLES = 3
   logic        a_rst = 1'b0, a_r = 1'b0, a_w = 1'b0;
   logic [31:0] a_addr = '0, a_wd = '0, a_rd;
   logic        a_rdy, a_err;
   // Instance B: WAIT_CYCLES = 0
   logic        b_rst = 1'b0, b_r = 1'b0, b_w = 1'b0;
   logic [31:0] b_addr = '0, b_wd = '0, b_rd;
   logic        b_rdy, b_err;

   data_mem_wait #(.DATA_W(32), .DEPTH(64), .ADDR_BASE(1024), .WAIT_CYCLES(3)) u_a (
      .clk(clk), .rst(a_rst), .mem_r_en(a_r), .mem_w_en(a_w), .address(a_addr),
      .wdata(a_wd), .rdata(a_rd), .ready(a_rdy), .addr_err(a_err));

   data_mem_wait #(.DATA_W(32), .DEPTH(64), .ADDR_BASE(1024), .WAIT_CYCLES(0)) u_b (
      .clk(clk), .rst(b_rst), .mem_r_en(b_r), .mem_w_en(b_w), .address(b_addr),
      .wdata(b_wd), .rdata(b_rd), .ready(b_rdy), .addr_err(b_err));

   int checks = 0;
   int errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   int stall_a = 0;
   int stall_b = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one access on instance u (0=A, 1=B); called just after a rising edge
   task automatic access(input int u, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] ed, input bit ee);
      exp_t e;
      int   n;
      bit   rdy;
      e.d = ed;
      e.e = ee;
      if (u == 0) begin
         qa.push_back(e);
         a_r = !wr; a_w = wr; a_addr = addr; a_wd = data;
      end else begin
         qb.push_back(e);
         b_r = !wr; b_w = wr; b_addr = addr; b_wd = data;
      end
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         rdy = (u == 0) ? a_rdy : b_rdy;
         if (rdy) break;
         if (n > 40) begin
            checks++;
            errors++;
            $display("FAIL timeout: inst %0d addr 0x%08h never completed", u, addr);
            break;
         end
      end
      @(posedge clk);
      #1;
      if (u == 0) begin a_r = 1'b0; a_w = 1'b0; end
      else        begin b_r = 1'b0; b_w = 1'b0; end
   endtask

   // Monitor A: compare each completion against the queue and the stall count
   always @(negedge clk) begin
      if (!a_rst || !(a_r || a_w)) begin
         stall_a = 0;
      end else if (!a_rdy) begin
         stall_a++;
      end else begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected: completion with empty queue, rdata 0x%08h", a_rd);
         end else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_rdata", a_rd, e.d);
            chk("a_addr_err", {31'd0, a_err}, {31'd0, e.e});
            chk("a_stall", stall_a, 3);
         end
         stall_a = 0;
      end
   end

   // Monitor B: same for the zero-wait instance; ready must never drop
   always @(negedge clk) begin
      if (!b_rst || !(b_r || b_w)) begin
         stall_b = 0;
      end else if (!b_rdy) begin
         stall_b++;
      end else begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: completion with empty queue, rdata 0x%08h", b_rd);
         end else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_rdata", b_rd, e.d);
            chk("b_addr_err", {31'd0, b_err}, {31'd0, e.e});
            chk("b_stall", stall_b, 0);
         end
         stall_b = 0;
      end
   end

   initial begin
      // Reset state before any clock edge
      #1;
      chk("rst_ready", {31'd0, a_rdy}, 32'd1);
      chk("rst_rdata", a_rd, 32'd0);
      chk("rst_err", {31'd0, a_err}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      a_r = 1'b1;
      #1;
      chk("rst_ready_req", {31'd0, a_rdy}, 32'd1);
      a_r = 1'b0;
      @(posedge clk);
      #1;
      a_rst = 1'b1;
      b_rst = 1'b1;
      chk("idle_ready", {31'd0, a_rdy}, 32'd1);

      // Every word reads back as zero after reset
      for (int i = 0; i < 64; i++)
         access(0, 1'b0, 32'd1024 + 32'(4 * i), 32'd0, 32'd0, 1'b0);

      // Write then back-to-back read
      access(0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd0, 1'b0);
      access(0, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, 1'b0);

      // Below base
      access(0, 1'b0, 32'd1020, 32'd0, 32'd0, 1'b1);

      // Misaligned write is dropped
      access(0, 1'b1, 32'd1024, 32'h11223344, 32'd0, 1'b0);
      access(0, 1'b1, 32'd1026, 32'h00000055, 32'd0, 1'b1);
      access(0, 1'b0, 32'd1024, 32'd0, 32'h11223344, 1'b0);

      // Last word and first word past the end
      access(0, 1'b1, 32'd1276, 32'hCAFEF00D, 32'd0, 1'b0);
      access(0, 1'b0, 32'd1276, 32'd0, 32'hCAFEF00D, 1'b0);
      access(0, 1'b1, 32'd1280, 32'h0BADF00D, 32'd0, 1'b1);
      access(0, 1'b0, 32'd1280, 32'd0, 32'd0, 1'b1);
      access(0, 1'b0, 32'd1024, 32'd0, 32'h11223344, 1'b0);

      // Abort: drop the write enable in cycle 1
      a_w = 1'b1; a_addr = 32'd1028; a_wd = 32'h77777777;
      @(negedge clk);
      chk("abort_c0_ready", {31'd0, a_rdy}, 32'd0);
      @(posedge clk);
      #1;
      a_w = 1'b0;
      #1;
      chk("abort_ready", {31'd0, a_rdy}, 32'd1);
      @(posedge clk);
      #1;
      access(0, 1'b0, 32'd1028, 32'd0, 32'd0, 1'b0);

      // Reset during cycle 2 of a write
      a_w = 1'b1; a_addr = 32'd1040; a_wd = 32'hAAAA5555;
      repeat (2) @(posedge clk);
      #1;
      a_rst = 1'b0;
      #1;
      chk("midrst_ready", {31'd0, a_rdy}, 32'd1);
      chk("midrst_rdata", a_rd, 32'd0);
      chk("midrst_err", {31'd0, a_err}, 32'd0);
      a_w = 1'b0;
      @(posedge clk);
      #1;
      a_rst = 1'b1;
      @(posedge clk);
      #1;
      access(0, 1'b0, 32'd1040, 32'd0, 32'd0, 1'b0);
      access(0, 1'b0, 32'd1032, 32'd0, 32'd0, 1'b0);

      // Zero-wait instance: write then read on consecutive cycles
      access(1, 1'b1, 32'd1024, 32'h12345678, 32'd0, 1'b0);
      access(1, 1'b0, 32'd1024, 32'd0, 32'h12345678, 1'b0);
      access(1, 1'b0, 32'd1020, 32'd0, 32'd0, 1'b1);
      access(1, 1'b1, 32'd1026, 32'h00000055, 32'd0, 1'b1);
      access(1, 1'b0, 32'd1024, 32'd0, 32'h12345678, 1'b0);

      repeat (5) @(posedge clk);
      chk("qa_empty", qa.size(), 32'd0);
      chk("qb_empty", qb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_wait.md
Name: data_mem_wait

Overview:
- Parametrised data memory for the MEM stage. It replaces the bare memory slot with a word-addressed RAM that has a configurable access latency.
- While an access is outstanding, ready is driven low. Upstream logic uses ~ready as the pipeline freeze, stalling every stage register, including the MEM stage register.
- Each access completes in exactly WAIT_CYCLES+1 cycles and reports out-of-range or misaligned addresses.

Parameters:
- DATA_W, 32: data word width.
- DEPTH, 64: number of words; must be a power of two.
- ADDR_BASE, 1024: byte address of word 0.
- WAIT_CYCLES, 3: stall cycles per access. Allowed range is 0..15.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_r_en  in  1  read request; held until ready.
- mem_w_en  in  1  write request; held until ready.
- address  in  32  byte address from the ALU result.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  load data; valid only while ready=1 and a read is active.
- ready  out  1  access complete, or no request; freeze = ~ready.
- addr_err  out  1  completed access had a bad address.

Behaviour:
- Request and decode:
  - req = mem_r_en | mem_w_en.
  - If both are high, the access is a write. rdata is 0.
  - idx = (address - ADDR_BASE) >> 2.
  - The address is bad if address < ADDR_BASE, address >= ADDR_BASE + 4*DEPTH, or address[1:0] != 0.
- Reset (rst=0, asynchronous): state=IDLE, counter=0, all memory words=0. Outputs go to ready=1, rdata=0, addr_err=0 immediately, with no clock needed.
- FSM states: IDLE and WAIT, plus a counter cnt of width clog2(WAIT_CYCLES+1), minimum 1 bit.
- IDLE:
  - No request: ready=1, rdata=0, addr_err=0.
  - Request and WAIT_CYCLES=0: ready=1 in the same cycle. The access completes at this edge.
  - Request and WAIT_CYCLES>0: ready=0. Next state is WAIT with cnt=1.
- WAIT:
  - cnt < WAIT_CYCLES: ready=0 and cnt increments.
  - cnt == WAIT_CYCLES: ready=1. This is the completion cycle. Next state is IDLE with cnt=0.
  - req dropping to 0 in WAIT is an abort. Next state is IDLE, no write occurs, and ready=1 because no request is present.
- Latency: request first seen in cycle 0 → ready=1 in cycle WAIT_CYCLES → exactly WAIT_CYCLES stall cycles.
- Completion cycle (ready=1 with req=1):
  - Write with a good address: mem[idx] <= wdata at the closing edge.
  - Read with a good address: rdata = mem[idx], combinational from the array during this cycle. In all other cycles rdata=0.
  - Bad address: addr_err=1 in this cycle only. A write is dropped and a read returns rdata=0.
- Back-to-back requests: after completion the FSM is in IDLE. A new request in the next cycle starts a fresh count, so no request is lost or merged.
- Stability: address, wdata and the enables must stay stable from the request until the completion cycle. Only a change to req=0 is defined (abort). Other mid-access changes take the value sampled at completion.
- Reset mid-WAIT: the access is abandoned and memory is cleared. ready=1 while rst=0.

Test Plan:
- Reset then idle (WAIT_CYCLES=3): rst low for 2 cycles, no requests → ready=1, rdata=0, addr_err=0. Every word read afterwards returns 0.
- Write then read (WAIT_CYCLES=3):
  - Write 0xDEADBEEF to 1032: ready low for cycles 0-2 and high in cycle 3.
  - Back-to-back read of 1032: ready low for 3 cycles, then rdata=0xDEADBEEF with ready=1.
- Zero wait (WAIT_CYCLES=0): write 0x12345678 to 1024, then read 1024 in the next cycle → ready never drops; rdata=0x12345678 in the read cycle.
- Bad addresses:
  - Read 1020 (below base) → addr_err=1 and rdata=0 in the completion cycle.
  - Write 0x55 to 1026 (misaligned) → addr_err=1. A following read of 1024 returns the prior value, showing the write was dropped.
- Wrap and abort:
  - Write to 1024+4*63=1276 succeeds. Write to 1280 → addr_err=1.
  - Drop mem_w_en in cycle 1 of a write to 1028 → ready=1 next cycle; a read of 1028 returns 0.
- Reset mid-access: assert rst low in cycle 2 of a write → ready=1 asynchronously. After release, reading the target address returns 0.
